// File: rtl/neural_network.sv
`default_nettype none
// ============================================================================
// Module      : neural_network (with package neural_network_pkg)
// Description : Fully connected feed-forward inference engine in signed
//               fixed point Q(INT_WIDTH).(FRAC_WIDTH). An input vector is
//               captured on inputs_ready. The dense layers are then evaluated
//               one after another. Each MAC cycle forms one product per
//               neuron, with all neurons of a layer working in parallel.
//               A bias/saturate/activation step closes each layer.
// Ports       : clock         in  1                  rising-edge clock
//               reset         in  1                  async active-low reset
//               inputs_ready  in  1                  start strobe (IDLE only)
//               inputs        in  DW x NUM_INPUTS    signed input vector
//               outputs_ready out 1                  one-cycle result strobe
//               outputs       out DW x NUM_OUTPUTS   signed results (held)
// Revision    : 1.0 - initial release
// ============================================================================

package neural_network_pkg;
  typedef enum logic {NONE = 1'b0, RELU = 1'b1} act_e;
  typedef struct packed {
    logic [15:0] num_neurons;
    act_e        activation;
  } layer_t;
endpackage

module neural_network
  import neural_network_pkg::*;
#(
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16,
  parameter int NUM_LAYERS = 3,
  parameter int NUM_INPUTS = 10,
  parameter layer_t [0:NUM_LAYERS-1] LAYERS = '{'{16'd16, RELU},
                                                '{16'd16, RELU},
                                                '{16'd10, RELU}},
  localparam int DW          = INT_WIDTH + FRAC_WIDTH,
  localparam int NUM_OUTPUTS = int'(LAYERS[NUM_LAYERS-1].num_neurons)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inputs_ready,
  input  logic signed [DW-1:0] inputs [NUM_INPUTS],
  output logic                 outputs_ready,
  output logic signed [DW-1:0] outputs [NUM_OUTPUTS]
);

  // Widest vector anywhere in the network sizes the shared x/acc storage.
  function automatic int calc_max_width();
    int m;
    m = NUM_INPUTS;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (int'(LAYERS[i].num_neurons) > m) m = int'(LAYERS[i].num_neurons);
    return m;
  endfunction

  localparam int MAXN = calc_max_width();
  localparam int KW   = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam int LW   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int AW   = DW + 8;

  // ROM image: unity weights and zero biases. All neurons share the same
  // weight, so one product per cycle feeds every accumulator.
  localparam logic signed [DW-1:0] W_ONE = DW'(64'd1 << FRAC_WIDTH);
  localparam logic signed [DW-1:0] BIAS  = '0;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic int fan_in_of(input logic [LW-1:0] l);
    int r;
    r = NUM_INPUTS;
    for (int i = 1; i < NUM_LAYERS; i++)
      if (int'(l) == i) r = int'(LAYERS[i-1].num_neurons);
    return r;
  endfunction

  function automatic int neurons_of(input logic [LW-1:0] l);
    int r;
    r = 0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (int'(l) == i) r = int'(LAYERS[i].num_neurons);
    return r;
  endfunction

  function automatic logic relu_of(input logic [LW-1:0] l);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (int'(l) == i) r = (LAYERS[i].activation == RELU);
    return r;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FIN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [LW-1:0]          layer_q, layer_d;
  logic [KW-1:0]          k_q, k_d;
  logic signed [DW-1:0]   x_q [MAXN];
  logic signed [DW-1:0]   x_d [MAXN];
  logic signed [AW-1:0]   acc_q [MAXN];
  logic signed [AW-1:0]   acc_d [MAXN];
  logic signed [DW-1:0]   outputs_q [NUM_OUTPUTS];
  logic signed [DW-1:0]   outputs_d [NUM_OUTPUTS];
  logic                   outputs_ready_q, outputs_ready_d;

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   term;
  logic signed [AW-1:0]   sum;
  logic signed [DW-1:0]   y;

  always_comb begin
    state_d         = state_q;
    layer_d         = layer_q;
    k_d             = k_q;
    x_d             = x_q;
    acc_d           = acc_q;
    outputs_d       = outputs_q;
    outputs_ready_d = 1'b0;
    prod            = '0;
    term            = '0;
    sum             = '0;
    y               = '0;

    case (state_q)
      S_IDLE: begin
        if (inputs_ready) begin
          for (int i = 0; i < NUM_INPUTS; i++) x_d[i] = inputs[i];
          for (int i = NUM_INPUTS; i < MAXN; i++) x_d[i] = '0;
          for (int n = 0; n < MAXN; n++) acc_d[n] = '0;
          layer_d = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end

      S_MAC: begin
        // Full-width product, then arithmetic shift back to Q format
        // (truncation toward -inf); the accumulator keeps 8 guard bits.
        prod = W_ONE * x_q[k_q];
        term = AW'(prod >>> FRAC_WIDTH);
        for (int n = 0; n < MAXN; n++) acc_d[n] = acc_q[n] + term;
        if (int'(k_q) == fan_in_of(layer_q) - 1) begin
          k_d     = '0;
          state_d = S_FIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      S_FIN: begin
        for (int n = 0; n < MAXN; n++) begin
          sum = acc_q[n] + AW'(BIAS);
          if (sum > SAT_MAX)      y = DW'(SAT_MAX);
          else if (sum < SAT_MIN) y = DW'(SAT_MIN);
          else                    y = DW'(sum);
          if (relu_of(layer_q) && y[DW-1]) y = '0;
          x_d[n]   = (n < neurons_of(layer_q)) ? y : '0;
          acc_d[n] = '0;
        end
        if (int'(layer_q) == NUM_LAYERS - 1) begin
          // Outputs and the strobe are loaded together on entry to DONE.
          for (int n = 0; n < NUM_OUTPUTS; n++) outputs_d[n] = x_d[n];
          outputs_ready_d = 1'b1;
          state_d         = S_DONE;
        end else begin
          layer_d = layer_q + LW'(1);
          state_d = S_MAC;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      layer_q         <= '0;
      k_q             <= '0;
      outputs_ready_q <= 1'b0;
      for (int n = 0; n < MAXN; n++) begin
        x_q[n]   <= '0;
        acc_q[n] <= '0;
      end
      for (int n = 0; n < NUM_OUTPUTS; n++) outputs_q[n] <= '0;
    end else begin
      state_q         <= state_d;
      layer_q         <= layer_d;
      k_q             <= k_d;
      outputs_ready_q <= outputs_ready_d;
      x_q             <= x_d;
      acc_q           <= acc_d;
      outputs_q       <= outputs_d;
    end
  end

  assign outputs_ready = outputs_ready_q;
  assign outputs       = outputs_q;

endmodule
`default_nettype wire

// File: tb/tb_neural_network.sv
`default_nettype none
// ============================================================================
// Module      : tb_neural_network
// Description : Self-checking bench for neural_network with default
//               parameters. It runs directed vectors from the functional
//               description, busy, held-strobe and reset-abort scenarios, and
//               random vectors compared against a plain-arithmetic network
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neural_network;

  localparam int N_IN  = 10;
  localparam int N_OUT = 10;
  localparam int NL    = 3;
  localparam int NEUR [NL] = '{16, 16, 10};
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam int EXP_LAT = 46;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inputs_ready = 1'b0;
  logic signed [31:0] inputs [N_IN];
  logic outputs_ready;
  logic signed [31:0] outputs [N_OUT];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  neural_network dut (
    .clock         (clk),
    .reset         (rst_n),
    .inputs_ready  (inputs_ready),
    .inputs        (inputs),
    .outputs_ready (outputs_ready),
    .outputs       (outputs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Network evaluated layer by layer with 64-bit arithmetic: unity weights,
  // zero biases, DW saturation, then RELU.
  function automatic void model(input logic signed [31:0] v [N_IN],
                                output logic signed [31:0] e [N_OUT]);
    longint cur [16];
    longint nxt [16];
    longint acc;
    int fan;
    for (int i = 0; i < 16; i++) cur[i] = 0;
    for (int i = 0; i < N_IN; i++) cur[i] = longint'(v[i]);
    fan = N_IN;
    for (int l = 0; l < NL; l++) begin
      for (int n = 0; n < 16; n++) nxt[n] = 0;
      for (int n = 0; n < NEUR[l]; n++) begin
        acc = 0;
        for (int k = 0; k < fan; k++) acc += (64'sd65536 * cur[k]) >>> 16;
        if (acc > SMAX) acc = SMAX;
        if (acc < SMIN) acc = SMIN;
        if (acc < 0) acc = 0;
        nxt[n] = acc;
      end
      cur = nxt;
      fan = NEUR[l];
    end
    for (int n = 0; n < N_OUT; n++) e[n] = 32'(cur[n]);
  endfunction

  // Drives one start pulse, waits for the strobe, checks latency, values,
  // one-cycle strobe width and output hold.
  task automatic do_run(input string tag, input logic signed [31:0] v [N_IN],
                        input logic signed [31:0] e [N_OUT]);
    int cyc;
    @(negedge clk);
    inputs = v;
    inputs_ready = 1'b1;
    @(negedge clk);
    inputs_ready = 1'b0;
    cyc = 1;
    while (!outputs_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(EXP_LAT));
    for (int n = 0; n < N_OUT; n++) check({tag, "_out"}, outputs[n], e[n]);
    @(negedge clk);
    check({tag, "_ready_width"}, 32'(outputs_ready), 32'd0);
    check({tag, "_hold"}, outputs[N_OUT-1], e[N_OUT-1]);
  endtask

  function automatic void fill(output logic signed [31:0] a [N_IN], input logic [31:0] val);
    for (int i = 0; i < N_IN; i++) a[i] = val;
  endfunction

  function automatic void fill_out(output logic signed [31:0] a [N_OUT], input logic [31:0] val);
    for (int i = 0; i < N_OUT; i++) a[i] = val;
  endfunction

  initial begin
    logic signed [31:0] v [N_IN];
    logic signed [31:0] e [N_OUT];
    int cyc;
    int first;

    fill(inputs, 32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(outputs_ready), 32'd0);
    for (int n = 0; n < N_OUT; n++) check("reset_out", outputs[n], 32'h0);
    rst_n = 1'b1;

    // Directed vectors with constant expectations
    fill(v, 32'h00010000); fill_out(e, 32'h0A000000); do_run("ones", v, e);
    fill(v, 32'h00008000); fill_out(e, 32'h05000000); do_run("halves", v, e);
    fill(v, 32'hFFFF0000); fill_out(e, 32'h00000000); do_run("neg_relu", v, e);
    fill(v, 32'h7FFFFFFF); fill_out(e, 32'h7FFFFFFF); do_run("saturate", v, e);

    // Busy: second strobe at cycle 10 carrying -1.0 must be ignored
    @(negedge clk);
    fill(inputs, 32'h00010000);
    inputs_ready = 1'b1;
    @(negedge clk);
    inputs_ready = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    fill(inputs, 32'hFFFF0000);
    inputs_ready = 1'b1;
    @(negedge clk);
    inputs_ready = 1'b0;
    cyc++;
    while (!outputs_ready && cyc < 200) begin @(negedge clk); cyc++; end
    check("busy_latency", 32'(cyc), 32'(EXP_LAT));
    for (int n = 0; n < N_OUT; n++) check("busy_out", outputs[n], 32'h0A000000);

    // Strobe held high: the next run starts on the first IDLE cycle after DONE
    @(negedge clk);
    fill(inputs, 32'h00008000);
    inputs_ready = 1'b1;
    cyc = 0;
    while (!outputs_ready && cyc < 200) begin @(negedge clk); cyc++; end
    check("held_first_latency", 32'(cyc), 32'(EXP_LAT));
    first = cyc;
    @(negedge clk); cyc++;
    while (!outputs_ready && cyc < 400) begin @(negedge clk); cyc++; end
    inputs_ready = 1'b0;
    check("held_gap", 32'(cyc - first), 32'(EXP_LAT + 1));
    check("held_out", outputs[0], 32'h05000000);
    repeat (3) @(negedge clk);

    // Reset at cycle 20 of a run aborts it and clears the outputs at once
    @(negedge clk);
    fill(inputs, 32'h00010000);
    inputs_ready = 1'b1;
    @(negedge clk);
    inputs_ready = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(outputs_ready), 32'd0);
    for (int n = 0; n < N_OUT; n++) check("abort_out", outputs[n], 32'h0);
    cyc = 0;
    repeat (60) begin
      @(negedge clk);
      if (outputs_ready) cyc++;
      if (cyc == 0) rst_n = 1'b1;
    end
    check("abort_no_strobe", 32'(cyc), 32'd0);
    fill(v, 32'h00010000); fill_out(e, 32'h0A000000); do_run("after_reset", v, e);

    // Random vectors against the model: small magnitudes and full range
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (r < 5) v[i] = $signed($urandom_range(32'h0008_0000, 0)) - 32'sh0004_0000;
        else       v[i] = $urandom;
      end
      model(v, e);
      do_run("random", v, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
